// File: rtl/wall_scheduler.sv
// rtl/wall_scheduler.sv - scrolls, spawns and streams wall slots once per accepted frame tick.
// Define WALL_SCHED_CLAMP_EN to clamp spawned heights to MAX_HEIGHT.
module wall_scheduler #(
    parameter int NUM_WALLS      = 4,
    parameter int SCREEN_W       = 160,
    parameter int SCROLL_STEP    = 1,
    parameter int SPAWN_INTERVAL = 40,
    parameter int MAX_HEIGHT     = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic       frame_tick,
    input  logic [7:0] height_in,
    output logic       wall_valid,
    input  logic       wall_ready,
    output logic [7:0] wall_x,
    output logic [7:0] wall_h,
    output logic [2:0] wall_id,
    output logic       frame_done,
    output logic       spawn_drop,
    output logic       frame_overrun
);

    localparam int IW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [7:0]    SPAWN_X  = 8'(SCREEN_W - 1);
    localparam logic [7:0]    STEP     = 8'(SCROLL_STEP);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WALLS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SPAWN_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, MOVE, SPAWN, EMIT, DONE} state_t;

    state_t                 state, state_n;
    logic [NUM_WALLS-1:0]   act, act_n;
    logic [7:0]             xs [NUM_WALLS];
    logic [7:0]             xs_n [NUM_WALLS];
    logic [7:0]             hs [NUM_WALLS];
    logic [7:0]             hs_n [NUM_WALLS];
    logic [IW-1:0]          idx, idx_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   drop_n, ovr_n, found;
    logic                   valid_n, done_n;
    logic [7:0]             x_n, h_n;
    logic [2:0]             id_n;
    logic [7:0]             spawn_h;

`ifdef WALL_SCHED_CLAMP_EN
    assign spawn_h = (height_in > 8'(MAX_HEIGHT)) ? 8'(MAX_HEIGHT) : height_in;
`else
    logic [7:0] unused_max_h;
    assign unused_max_h = 8'(MAX_HEIGHT);
    assign spawn_h      = height_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_tick && run) state_n = MOVE;
            MOVE:    state_n = (cnt == LAST_CNT) ? SPAWN : EMIT;
            SPAWN:   state_n = EMIT;
            EMIT:    if ((!act[idx] || wall_ready) && idx == LAST_IDX) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    // Slot, counter and flag updates; outputs below present the slot the next cycle will show.
    always_comb begin
        act_n  = act;
        xs_n   = xs;
        hs_n   = hs;
        idx_n  = idx;
        cnt_n  = cnt;
        drop_n = spawn_drop;
        ovr_n  = frame_overrun;
        found  = 1'b0;
        if (frame_tick && state != IDLE) ovr_n = 1'b1;
        case (state)
            MOVE: begin
                idx_n = '0;
                cnt_n = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
                for (int i = 0; i < NUM_WALLS; i++) begin
                    if (act[i]) begin
                        if (xs[i] < STEP) act_n[i] = 1'b0;
                        else              xs_n[i]  = xs[i] - STEP;
                    end
                end
            end
            SPAWN: begin
                idx_n = '0;
                for (int i = 0; i < NUM_WALLS; i++) begin
                    if (!act[i] && !found) begin
                        found    = 1'b1;
                        act_n[i] = 1'b1;
                        xs_n[i]  = SPAWN_X;
                        hs_n[i]  = spawn_h;
                    end
                end
                if (!found) drop_n = 1'b1;
            end
            EMIT: begin
                if ((!act[idx] || wall_ready) && idx != LAST_IDX) idx_n = idx + 1'b1;
            end
            default: ;
        endcase
        if (clear) begin
            act_n  = '0;
            cnt_n  = '0;
            idx_n  = '0;
            drop_n = 1'b0;
            ovr_n  = 1'b0;
        end
    end

    always_comb begin
        valid_n = (state_n == EMIT) && act_n[idx_n];
        x_n     = valid_n ? xs_n[idx_n] : wall_x;
        h_n     = valid_n ? hs_n[idx_n] : wall_h;
        id_n    = valid_n ? 3'(idx_n) : wall_id;
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act           <= '0;
            xs            <= '{default: '0};
            hs            <= '{default: '0};
            idx           <= '0;
            cnt           <= '0;
            wall_valid    <= 1'b0;
            wall_x        <= '0;
            wall_h        <= '0;
            wall_id       <= '0;
            frame_done    <= 1'b0;
            spawn_drop    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            act           <= act_n;
            xs            <= xs_n;
            hs            <= hs_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            wall_valid    <= valid_n;
            wall_x        <= x_n;
            wall_h        <= h_n;
            wall_id       <= id_n;
            frame_done    <= done_n;
            spawn_drop    <= drop_n;
            frame_overrun <= ovr_n;
        end
    end

endmodule

// File: doc/wall_scheduler.md
# wall_scheduler

Frame-level controller for the scrolling walls. It owns NUM_WALLS wall slots, each holding an x position and a height. On every accepted frame tick it scrolls all active walls left and retires walls that leave the screen. Every SPAWN_INTERVAL frames it spawns a new wall, sampling the free-running wall height generator. It then streams each active wall to the draw engine over a valid/ready handshake. It sits between the height generator, the frame timer and the VGA draw FSM.

## Interface
Parameters:
- NUM_WALLS, 4: number of wall slots (2..8).
- SCREEN_W, 160: spawn x is SCREEN_W-1 (max 256).
- SCROLL_STEP, 1: pixels moved per frame.
- SPAWN_INTERVAL, 40: frames between spawns (≥1).
- MAX_HEIGHT, 90: clamp ceiling, used only with WALL_SCHED_CLAMP_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous game restart.
- run, in, 1: game active; frame ticks are ignored while low.
- frame_tick, in, 1: one-cycle pulse per frame.
- height_in, in, 8: current wall height generator output.
- wall_valid, out, 1: wall descriptor valid.
- wall_ready, in, 1: draw engine accepts the descriptor.
- wall_x, out, 8: x of the presented wall.
- wall_h, out, 8: height of the presented wall.
- wall_id, out, 3: slot index of the presented wall.
- frame_done, out, 1: one-cycle pulse when the frame's emission completes.
- spawn_drop, out, 1: sticky; a spawn found no free slot.
- frame_overrun, out, 1: sticky; frame_tick arrived while not IDLE.

## Operation
- States: IDLE, MOVE, SPAWN, EMIT, DONE.
- IDLE
  - frame_tick && run → MOVE.
  - frame_tick && !run → ignored, no flag.
- MOVE (1 cycle)
  - Each active slot with x < SCROLL_STEP is deactivated; every other active slot gets x -= SCROLL_STEP.
  - Spawn counter: if cnt == SPAWN_INTERVAL-1, then cnt←0 and go to SPAWN; else cnt+1 and go to EMIT with idx=0.
- SPAWN (1 cycle)
  - The lowest-index inactive slot becomes active with x=SCREEN_W-1 and h=height_in, sampled this cycle.
  - The new slot is not scrolled until the next frame.
  - If no slot is free, the spawn is discarded and spawn_drop←1.
  - Then go to EMIT with idx=0.
- EMIT: scans idx 0..NUM_WALLS-1 in order.
  - Inactive slot: skipped in one cycle, wall_valid stays 0.
  - Active slot: wall_valid=1, with wall_x, wall_h and wall_id=idx held stable until wall_ready is seen high on a rising edge. The scan then advances.
  - After the last idx → DONE.
- DONE (1 cycle): frame_done=1, then IDLE.
- frame_tick in any non-IDLE state: ignored, and frame_overrun←1. The frame in progress is not restarted.
- run falling mid-frame: the current frame completes normally.
- clear, in any state, highest priority after reset:
  - All slots inactive, cnt←0, sticky flags←0, wall_valid←0.
  - Next state IDLE. A frame_tick in the same cycle is ignored.
- x arithmetic is 8-bit unsigned and never wraps; a wall reaching x < SCROLL_STEP is retired instead.

## Timing
- All outputs are registered.
- Reset values: wall_valid 0, wall_x 0, wall_h 0, wall_id 0, frame_done 0, spawn_drop 0, frame_overrun 0. All slots inactive, cnt=0, state IDLE.
- Latency from tick to emission, with the tick sampled at edge T:
  - MOVE occupies cycle T+1.
  - SPAWN, if taken, occupies T+2.
  - The first EMIT cycle is T+2, or T+3 after a spawn.
- With no active slots, EMIT lasts NUM_WALLS cycles.
- Each active slot adds one cycle per ready-low stall cycle.
- wall_valid is never deasserted without a handshake, except on clear or reset.
- First spawn happens on the SPAWN_INTERVAL-th accepted frame after reset or clear.
- Slot ordering is by index, not by x.

## Configuration
- WALL_SCHED_CLAMP_EN defined: the spawn stores h = min(height_in, MAX_HEIGHT).
- WALL_SCHED_CLAMP_EN undefined: height_in is stored unmodified and MAX_HEIGHT is unused.

## Test plan
- Reset with run=1, wall_ready=1, and 40 frame_ticks spaced 20 cycles apart, height_in=33. Required response:
  - One spawn on the 40th tick; slot 0 is emitted with x=159, h=33, id=0.
  - frame_done is seen 40 times.
- Continue 159 more frames without further spawn interference (SPAWN_INTERVAL=200 build). Required response:
  - Slot 0 x decrements to 0.
  - The next frame retires it, and no wall_valid follows in that frame.
- SPAWN_INTERVAL=1, NUM_WALLS=4, 5 ticks. Required response:
  - Slots 0..3 fill.
  - The 5th spawn sets spawn_drop=1.
  - Four walls are emitted per frame.
- Hold wall_ready=0 for 10 cycles during EMIT. Required response:
  - wall_valid, wall_x, wall_h and wall_id stay stable.
  - A frame_tick during the stall sets frame_overrun=1 and does not restart the frame.
- Assert clear mid-EMIT. Required response:
  - Next cycle wall_valid=0, state IDLE, sticky flags=0.
  - A following 40 ticks respawn starting at slot 0.
- Clamp build with height_in=200, MAX_HEIGHT=90. Required response: the spawned wall_h=90. In the non-clamp build, wall_h=200.
